// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive path (and a later
// oversampled transmitter).
//   rx_state_t : receiver FSM state encoding
//   uart_div   : clocks per oversample tick, clk_freq / (baud * os)
//   maj3       : 2-of-3 majority used for the bit vote
//   xor8       : byte parity (XOR reduction)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic xor8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
// Emits a one-cycle tick every DIV = clk_freq/(baud_rate*OS) clocks.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous reset, active high (clears divider and tick)
//   tick out one-cycle pulse per oversample period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int OS        = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = uart_div(clk_freq, baud_rate, OS);
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // A divider below 2 cannot produce a distinct tick; refuse to elaborate.
  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_baud_tick: clk_freq/(baud_rate*OS) must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  // Divider counter and registered tick pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled 8N1 UART receiver (optional parity), LSB first,
// running entirely on the system clock.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active high
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  received byte, stable while rx_valid
//   rx_valid   out  byte available; held until accepted
//   rx_ready   in   consumer accepts on rx_valid && rx_ready
//   frame_err  out  stop bit sampled 0 (qualified by rx_valid)
//   parity_err out  parity mismatch (qualified by rx_valid)
//   overrun    out  one-cycle pulse: a completed byte was dropped
//   busy       out  receiver not in IDLE
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int OS         = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int SCW = $clog2(OS);
  localparam logic [SCW-1:0] SC_S0   = SCW'(OS / 2 - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(OS / 2);
  localparam logic [SCW-1:0] SC_VOTE = SCW'(OS / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  // The three vote samples straddle mid-bit; this needs an even ratio of at least 8.
  generate
    if ((OS < 8) || ((OS % 2) != 0)) begin : g_os_check
      $error("uart_rx_os: OS must be even and >= 8");
    end
  endgenerate

  logic            tick;
  logic            sync1;
  logic            rxs;
  logic            armed;
  logic [SCW-1:0]  sc;
  logic [2:0]      bc;
  logic            s0;
  logic            s1;
  logic [7:0]      shreg;
  logic            perr_pend;
  logic            done;
  logic            done_ferr;
  logic            vote;
  logic            at_vote;
  logic            at_wrap;
  logic            start_det;
  rx_state_t       state;
  rx_state_t       state_next;

  uart_baud_tick #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate),
    .OS       (OS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // The third vote sample is the live rxs at the vote tick itself.
  assign vote      = maj3(s0, s1, rxs);
  assign at_vote   = tick && (sc == SC_VOTE);
  assign at_wrap   = tick && (sc == SC_LAST);
  // A start is only accepted after the line has been seen high in IDLE.
  assign start_det = armed && !rxs && tick;
  assign busy      = (state != IDLE);

  // Two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; STOP leaves at the vote so back-to-back frames are caught
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_next = IDLE;
        end else if (at_wrap) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (at_wrap && (bc == 3'd7)) begin
          state_next = PAR_EN ? PARITY : STOP;
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (at_wrap) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        if (at_vote) begin
          state_next = IDLE;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sample counter, vote samples, shifter, parity check and frame completion
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      sc        <= '0;
      bc        <= 3'd0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= 8'h00;
      perr_pend <= 1'b0;
      done      <= 1'b0;
      done_ferr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (rxs) begin
          armed <= 1'b1;
        end
        if (start_det) begin
          sc        <= '0;
          bc        <= 3'd0;
          perr_pend <= 1'b0;
        end
      end else if (tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        if (sc == SC_S0) begin
          s0 <= rxs;
        end
        if (sc == SC_S1) begin
          s1 <= rxs;
        end
        if (sc == SC_VOTE) begin
          case (state)
            DATA: begin
              shreg <= {vote, shreg[7:1]};
            end
            PARITY: begin
              if (vote != (xor8(shreg) ^ PAR_ODD)) begin
                perr_pend <= 1'b1;
              end
            end
            STOP: begin
              done      <= 1'b1;
              done_ferr <= ~vote;
              // A low stop (break) must see the line return high before re-arming.
              if (!vote) begin
                armed <= 1'b0;
              end
            end
            default: begin
            end
          endcase
        end
        if ((state == DATA) && (sc == SC_LAST)) begin
          bc <= bc + 3'd1;
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= done_ferr;
          parity_err <= perr_pend;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
